// File: rtl/admo_muldiv_if.sv
// rtl/admo_muldiv_if.sv - request/response bundle between execute stage and admo_muldiv
interface admo_muldiv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_i;
    logic                  ready_o;
    logic [2:0]            operator_i;
    logic [DATA_WIDTH-1:0] operand_a_i;
    logic [DATA_WIDTH-1:0] operand_b_i;
    logic                  kill_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [DATA_WIDTH-1:0] result_o;

    modport master (
        output valid_i, operator_i, operand_a_i, operand_b_i, kill_i, ready_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  valid_i, operator_i, operand_a_i, operand_b_i, kill_i, ready_i,
        output ready_o, valid_o, result_o
    );
endinterface

// File: rtl/admo_muldiv.sv
// rtl/admo_muldiv.sv - iterative RV32M multiply/divide unit (shift-add / restoring)
module admo_muldiv #(
    parameter int DATA_WIDTH = 32,
    parameter bit EARLY_OUT  = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    admo_muldiv_if.slave   bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t          state;
    logic [2:0]      op;
    logic            neg;
    logic            special;
    logic [W-1:0]    special_val;
    logic [W-1:0]    divisor;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    rem;
    logic [CW-1:0]   cnt;

    logic            is_div, a_signed, b_signed, a_neg, b_neg, spec_hit;
    logic [W-1:0]    a_mag, b_mag, min_val, spec_res;
    logic [W:0]      mul_sum, div_shift, div_diff;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    quo, rmd, fix_res;

    // Accept-time decode: sign handling and the results that need no iteration
    always_comb begin
        is_div   = bus.operator_i[2];
        a_signed = is_div ? !bus.operator_i[0]
                          : (bus.operator_i == 3'd1 || bus.operator_i == 3'd2);
        b_signed = is_div ? !bus.operator_i[0] : (bus.operator_i == 3'd1);
        a_neg    = a_signed & bus.operand_a_i[W-1];
        b_neg    = b_signed & bus.operand_b_i[W-1];
        a_mag    = a_neg ? (~bus.operand_a_i + 1'b1) : bus.operand_a_i;
        b_mag    = b_neg ? (~bus.operand_b_i + 1'b1) : bus.operand_b_i;
        min_val  = {1'b1, {(W-1){1'b0}}};
        spec_hit = 1'b0;
        spec_res = '0;
        if (is_div) begin
            if (bus.operand_b_i == '0) begin
                spec_hit = 1'b1;
                spec_res = bus.operator_i[1] ? bus.operand_a_i : '1;
            end else if (a_signed && bus.operand_a_i == min_val && bus.operand_b_i == '1) begin
                spec_hit = 1'b1;
                spec_res = bus.operator_i[1] ? '0 : min_val;
            end
        end else if (bus.operand_a_i == '0 || bus.operand_b_i == '0) begin
            spec_hit = 1'b1;
        end
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, divisor} : '0);
        div_shift = {rem, acc[W-1]};
        div_diff  = div_shift - {1'b0, divisor};
        prod      = neg ? (~acc + 1'b1) : acc;
        quo       = neg ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
        rmd       = neg ? (~rem + 1'b1) : rem;
        if (special)
            fix_res = special_val;
        else if (!op[2])
            fix_res = (op == 3'd0) ? prod[W-1:0] : prod[2*W-1:W];
        else
            fix_res = op[1] ? rmd : quo;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            bus.ready_o  <= 1'b1;
            bus.valid_o  <= 1'b0;
            bus.result_o <= '0;
            op           <= '0;
            neg          <= 1'b0;
            special      <= 1'b0;
            special_val  <= '0;
            divisor      <= '0;
            acc          <= '0;
            rem          <= '0;
            cnt          <= '0;
        end else if (bus.kill_i) begin
            state       <= S_IDLE;
            bus.ready_o <= 1'b1;
            bus.valid_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.valid_i) begin
                    op          <= bus.operator_i;
                    // Remainder sign follows the dividend only
                    neg         <= (is_div && bus.operator_i[1]) ? a_neg : (a_neg ^ b_neg);
                    special     <= spec_hit;
                    special_val <= spec_res;
                    divisor     <= b_mag;
                    acc         <= {{W{1'b0}}, a_mag};
                    rem         <= '0;
                    cnt         <= CW'(W);
                    bus.ready_o <= 1'b0;
                    if (EARLY_OUT && spec_hit) begin
                        state        <= S_DONE;
                        bus.valid_o  <= 1'b1;
                        bus.result_o <= spec_res;
                    end else begin
                        state <= is_div ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    acc <= {mul_sum, acc[W-1:1]};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_FIX;
                end
                S_DIV: begin
                    rem          <= div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
                    acc[W-1:0]   <= {acc[W-2:0], ~div_diff[W]};
                    cnt          <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    bus.result_o <= fix_res;
                    bus.valid_o  <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE: if (bus.ready_i) begin
                    bus.valid_o <= 1'b0;
                    bus.ready_o <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_admo_muldiv.sv
// tb/tb_admo_muldiv.sv - checks admo_muldiv at 32 bits (early-out) and 16 bits (full iteration)
module tb_admo_muldiv;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    admo_muldiv_if #(.DATA_WIDTH(32)) bus32 ();
    admo_muldiv_if #(.DATA_WIDTH(16)) bus16 ();

    admo_muldiv #(.DATA_WIDTH(32), .EARLY_OUT(1'b1)) dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(bus32));
    admo_muldiv #(.DATA_WIDTH(16), .EARLY_OUT(1'b0)) dut16 (.clk_i(clk), .rst_ni(rst_n), .bus(bus16));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
        logic [63:0] mask, xa_u, xb_u, xa_s, xb_s, r;
        longint sa, sb, ua, ub, q;
        mask = (64'd1 << w) - 64'd1;
        xa_u = {32'd0, a} & mask;
        xb_u = {32'd0, b} & mask;
        xa_s = xa_u[w-1] ? (xa_u | ~mask) : xa_u;
        xb_s = xb_u[w-1] ? (xb_u | ~mask) : xb_u;
        sa = xa_s; sb = xb_s; ua = xa_u; ub = xb_u;
        case (op)
            3'd0: r = xa_u * xb_u;
            3'd1: r = (xa_s * xb_s) >> w;
            3'd2: r = (xa_s * xb_u) >> w;
            3'd3: r = (xa_u * xb_u) >> w;
            3'd4: begin q = (ub == 0) ? -64'sd1 : sa / sb; r = q; end
            3'd5: begin q = (ub == 0) ? -64'sd1 : ua / ub; r = q; end
            3'd6: begin q = (ub == 0) ? sa : sa % sb; r = q; end
            default: begin q = (ub == 0) ? ua : ua % ub; r = q; end
        endcase
        r = r & mask;
        return r[31:0];
    endfunction

    function automatic bit early32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 3'd4)
            return (b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (a == 0) || (b == 0);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_8000;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issues one op to both units in the same cycle and checks result and latency of each
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r32);
        int          lat32, lat16;
        logic [15:0] r16;
        logic [31:0] e32, e16;
        lat32 = -1; lat16 = -1; r32 = '0; r16 = '0;
        @(negedge clk);
        chk("issue_rdy32", {63'd0, bus32.ready_o}, 64'd1);
        bus32.valid_i = 1'b1; bus32.operator_i = op; bus32.operand_a_i = a; bus32.operand_b_i = b;
        bus16.valid_i = 1'b1; bus16.operator_i = op; bus16.operand_a_i = a[15:0]; bus16.operand_b_i = b[15:0];
        bus32.ready_i = 1'b1; bus16.ready_i = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            bus32.valid_i = 1'b0; bus16.valid_i = 1'b0;
            if (lat32 < 0 && bus32.valid_o) begin lat32 = c; r32 = bus32.result_o; end
            if (lat16 < 0 && bus16.valid_o) begin lat16 = c; r16 = bus16.result_o; end
            if (lat32 >= 0 && lat16 >= 0) break;
        end
        e32 = ref_op(op, a, b, 32);
        e16 = ref_op(op, a, b, 16);
        chk($sformatf("res32 op%0d a=%h b=%h", op, a, b), {32'd0, r32}, {32'd0, e32});
        chk($sformatf("res16 op%0d a=%h b=%h", op, a[15:0], b[15:0]), {48'd0, r16}, {48'd0, e16[15:0]});
        chk("lat32", 64'(lat32), early32(op, a, b) ? 64'd1 : 64'd34);
        chk("lat16", 64'(lat16), 64'd18);
    endtask

    initial begin
        logic [31:0] r;
        logic        got;
        rst_n = 1'b0;
        bus32.valid_i = 0; bus32.operator_i = 0; bus32.operand_a_i = 0; bus32.operand_b_i = 0;
        bus32.kill_i = 0; bus32.ready_i = 0;
        bus16.valid_i = 0; bus16.operator_i = 0; bus16.operand_a_i = 0; bus16.operand_b_i = 0;
        bus16.kill_i = 0; bus16.ready_i = 0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", {63'd0, bus32.ready_o}, 64'd1);
        chk("rst_valid", {63'd0, bus32.valid_o}, 64'd0);
        chk("rst_res", {32'd0, bus32.result_o}, 64'd0);
        rst_n = 1'b1;

        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, r); chk("mulh", {32'd0, r}, 64'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFFF, 32'd2, r); chk("mulhu", {32'd0, r}, 64'h1);
        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, r); chk("mul", {32'd0, r}, 64'hFFFF_FFFE);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, r); chk("div", {32'd0, r}, 64'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, r); chk("rem", {32'd0, r}, 64'hFFFF_FFFF);
        run_op(3'd5, 32'd100, 32'd7, r);       chk("divu", {32'd0, r}, 64'd14);
        run_op(3'd7, 32'd100, 32'd7, r);       chk("remu", {32'd0, r}, 64'd2);
        run_op(3'd4, 32'h1234, 32'd0, r);      chk("div0", {32'd0, r}, 64'hFFFF_FFFF);
        run_op(3'd5, 32'h1234, 32'd0, r);      chk("divu0", {32'd0, r}, 64'hFFFF_FFFF);
        run_op(3'd6, 32'h1234, 32'd0, r);      chk("rem0", {32'd0, r}, 64'h1234);
        run_op(3'd7, 32'h1234, 32'd0, r);      chk("remu0", {32'd0, r}, 64'h1234);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, r); chk("div_ovf", {32'd0, r}, 64'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, r); chk("rem_ovf", {32'd0, r}, 64'd0);

        // Consumer stall in DONE
        @(negedge clk);
        bus32.valid_i = 1'b1; bus32.operator_i = 3'd0; bus32.operand_a_i = 32'd3; bus32.operand_b_i = 32'd5;
        bus32.ready_i = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            bus32.valid_i = 1'b0;
            got = bus32.valid_o;
        end
        chk("hold_arrive", {63'd0, got}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {63'd0, bus32.valid_o}, 64'd1);
            chk("hold_res", {32'd0, bus32.result_o}, 64'd15);
            chk("hold_rdy", {63'd0, bus32.ready_o}, 64'd0);
            bus32.valid_i = 1'b1; bus32.operator_i = 3'd5; bus32.operand_a_i = 32'd9; bus32.operand_b_i = 32'd3;
            @(negedge clk);
        end
        bus32.valid_i = 1'b0; bus32.ready_i = 1'b1;
        @(negedge clk);
        chk("rel_rdy", {63'd0, bus32.ready_o}, 64'd1);
        chk("rel_valid", {63'd0, bus32.valid_o}, 64'd0);
        chk("rel_res_kept", {32'd0, bus32.result_o}, 64'd15);

        // Kill mid-divide, then kill racing a request in IDLE
        bus32.valid_i = 1'b1; bus32.operator_i = 3'd4; bus32.operand_a_i = 32'd1000; bus32.operand_b_i = 32'd7;
        @(negedge clk);
        bus32.valid_i = 1'b0;
        repeat (9) @(negedge clk);
        bus32.kill_i = 1'b1;
        @(negedge clk);
        bus32.kill_i = 1'b0;
        chk("kill_rdy", {63'd0, bus32.ready_o}, 64'd1);
        got = 1'b0;
        repeat (40) begin @(negedge clk); got = got | bus32.valid_o; end
        chk("kill_no_valid", {63'd0, got}, 64'd0);
        chk("kill_res_kept", {32'd0, bus32.result_o}, 64'd15);
        bus32.valid_i = 1'b1; bus32.kill_i = 1'b1; bus32.operator_i = 3'd0;
        @(negedge clk);
        bus32.valid_i = 1'b0; bus32.kill_i = 1'b0;
        chk("kill_idle_rdy", {63'd0, bus32.ready_o}, 64'd1);
        run_op(3'd0, 32'd3, 32'd5, r); chk("post_kill_mul", {32'd0, r}, 64'd15);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        bus32.valid_i = 1'b1; bus32.operator_i = 3'd0; bus32.operand_a_i = 32'd7; bus32.operand_b_i = 32'd9;
        bus16.valid_i = 1'b1; bus16.operator_i = 3'd0; bus16.operand_a_i = 16'd7; bus16.operand_b_i = 16'd9;
        @(negedge clk);
        bus32.valid_i = 1'b0; bus16.valid_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rdy", {63'd0, bus32.ready_o}, 64'd1);
        chk("arst_valid", {63'd0, bus32.valid_o}, 64'd0);
        chk("arst_res", {32'd0, bus32.result_o}, 64'd0);
        chk("arst_rdy16", {63'd0, bus16.ready_o}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        got = 1'b0;
        repeat (40) begin @(negedge clk); got = got | bus32.valid_o | bus16.valid_o; end
        chk("arst_no_valid", {63'd0, got}, 64'd0);

        for (int i = 0; i < 400; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(op, a, b, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
